// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
// Holds the FSM state encoding and the default address/data widths.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_t;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns single-beat valid/ready commands into APB
// SETUP/ACCESS transfers and returns PRDATA/PSLVERR on a response strobe.
// Ports: PCLK, PRESET (sync, active high); cmd_valid/ready/write/addr/wdata;
// rsp_valid/rdata/err/timeout; PSEL/PENABLE/PWRITE/PADDR/PWDATA out;
// PRDATA/PREADY/PSLVERR in.
// Optional watchdog on ACCESS wait states: APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t state;
  apb_state_t state_n;

  logic              cmd_ready_n;
  logic              psel_n;
  logic              penable_n;
  logic              pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;
  logic              rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic              rsp_err_n;

  logic accept;
  logic done;
  logic abort;

  // cmd_ready is registered, so it is low in the reset cycle
  // and the IDLE check only guards against illegal encodings.
  assign accept = (state == APB_IDLE) && cmd_valid && cmd_ready;
  assign done   = (state == APB_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_n;
  logic             tmo_q;
  logic             tmo_n;

  // Abort on the edge the stall count would reach the limit;
  // a PREADY on that same edge takes priority through done.
  assign abort = (state == APB_ACCESS) && !PREADY &&
                 (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_n = wd_cnt;
    if (accept) begin
      wd_cnt_n = '0;
    end else if ((state == APB_ACCESS) && !PREADY) begin
      wd_cnt_n = wd_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    tmo_n = tmo_q;
    if (done) begin
      tmo_n = 1'b0;
    end else if (abort) begin
      tmo_n = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wd_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_n;
      tmo_q  <= tmo_n;
    end
  end

  assign rsp_timeout = tmo_q;
`else
  logic unused_tmo;

  assign abort       = 1'b0;
  assign unused_tmo  = (TIMEOUT_CYCLES != 0);
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cmd_ready_n = 1'b0;
    psel_n      = PSEL;
    penable_n   = PENABLE;
    pwrite_n    = PWRITE;
    paddr_n     = PADDR;
    pwdata_n    = PWDATA;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;

    unique case (state)
      APB_IDLE: begin
        cmd_ready_n = 1'b1;
        psel_n      = 1'b0;
        penable_n   = 1'b0;
        if (accept) begin
          state_n     = APB_SETUP;
          cmd_ready_n = 1'b0;
          psel_n      = 1'b1;
          pwrite_n    = cmd_write;
          paddr_n     = cmd_addr;
          pwdata_n    = cmd_wdata;
        end
      end
      APB_SETUP: begin
        state_n   = APB_ACCESS;
        psel_n    = 1'b1;
        penable_n = 1'b1;
      end
      APB_ACCESS: begin
        if (done || abort) begin
          state_n     = APB_IDLE;
          cmd_ready_n = 1'b1;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = done ? PSLVERR : 1'b1;
          rsp_rdata_n = (done && !PWRITE) ? PRDATA : '0;
        end
      end
      default: begin
        state_n   = APB_IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= APB_IDLE;
      cmd_ready <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
      PWRITE    <= pwrite_n;
      PADDR     <= paddr_n;
      PWDATA    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule
